// File: rtl/com_ms.sv
// Host-side link control sequencer: sends commands with timeout/retry and
// acknowledges then forwards unsolicited DATA packets from the node.
module com_ms #(
  parameter logic [31:0] TIMEOUT    = 32'd900,
  parameter logic [7:0]  NUM_RETRY  = 8'h03,
  parameter logic [3:0]  BTYPE_INFO = 4'h1,
  parameter logic [3:0]  BTYPE_DATA = 4'hE,
  parameter logic [3:0]  BTYPE_ACK  = 4'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_cmd,
  output logic        fd_cmd,
  input  logic [3:0]  cmd_btype,
  output logic        fs_com_send,
  input  logic        fd_com_send,
  input  logic        fs_com_read,
  output logic        fd_com_read,
  output logic [3:0]  com_tx_btype,
  input  logic [3:0]  com_rx_btype,
  output logic        fs_data,
  input  logic        fd_data,
  output logic [3:0]  rsp_btype,
  output logic        cmd_err,
  output logic [15:0] data_cnt,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [9:0] {
    MAIN_IDLE = 10'b00_0000_0001,
    MAIN_WAIT = 10'b00_0000_0010,
    CMD_SEND  = 10'b00_0000_0100,
    CMD_WAIT  = 10'b00_0000_1000,
    CMD_WORK  = 10'b00_0001_0000,
    CMD_DONE  = 10'b00_0010_0000,
    RX_IDLE   = 10'b00_0100_0000,
    RX_WORK   = 10'b00_1000_0000,
    RX_ACK    = 10'b01_0000_0000,
    RX_FWD    = 10'b10_0000_0000
  } state_t;

  state_t      state_r;
  logic [31:0] time_cnt_r;
  logic [7:0]  retry_cnt_r;
  logic [3:0]  rx_type_r;

  // Sequencer; handshake outputs are set on the edge that enters the state that drives them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= MAIN_IDLE;
      time_cnt_r   <= 32'd0;
      retry_cnt_r  <= 8'd0;
      rx_type_r    <= 4'd0;
      com_tx_btype <= 4'd0;
      rsp_btype    <= 4'd0;
      cmd_err      <= 1'b0;
      data_cnt     <= 16'd0;
      drop_cnt     <= 8'd0;
      fs_com_send  <= 1'b0;
      fd_com_read  <= 1'b0;
      fd_cmd       <= 1'b0;
      fs_data      <= 1'b0;
    end else begin
      fs_com_send <= 1'b0;
      fd_com_read <= 1'b0;
      fd_cmd      <= 1'b0;
      fs_data     <= 1'b0;
      time_cnt_r  <= 32'd0;
      case (state_r)
        MAIN_IDLE: begin
          com_tx_btype <= 4'h0;
          state_r      <= MAIN_WAIT;
        end
        MAIN_WAIT: begin
          if (fs_com_read) begin
            state_r <= RX_IDLE;
          end else if (fs_cmd) begin
            com_tx_btype <= cmd_btype;
            retry_cnt_r  <= 8'd0;
            cmd_err      <= 1'b0;
            fs_com_send  <= 1'b1;
            state_r      <= CMD_SEND;
          end else begin
            state_r <= MAIN_WAIT;
          end
        end
        CMD_SEND: begin
          if (fd_com_send) begin
            state_r <= CMD_WAIT;
          end else begin
            fs_com_send <= 1'b1;
          end
        end
        CMD_WAIT: begin
          if (fs_com_read) begin
            rsp_btype   <= com_rx_btype;
            fd_com_read <= 1'b1;
            state_r     <= CMD_WORK;
          end else if ((time_cnt_r >= TIMEOUT - 32'd1) && (retry_cnt_r >= NUM_RETRY - 8'd1)) begin
            cmd_err <= 1'b1;
            fd_cmd  <= 1'b1;
            state_r <= CMD_DONE;
          end else if (time_cnt_r >= TIMEOUT - 32'd1) begin
            retry_cnt_r <= retry_cnt_r + 8'd1;
            fs_com_send <= 1'b1;
            state_r     <= CMD_SEND;
          end else begin
            time_cnt_r <= time_cnt_r + 32'd1;
          end
        end
        CMD_WORK: begin
          // Any reply type ends the wait; only INFO counts as success.
          if (!fs_com_read) begin
            cmd_err <= (rsp_btype != BTYPE_INFO);
            fd_cmd  <= 1'b1;
            state_r <= CMD_DONE;
          end else begin
            fd_com_read <= 1'b1;
          end
        end
        CMD_DONE: begin
          if (!fs_cmd) begin
            state_r <= MAIN_WAIT;
          end else begin
            fd_cmd <= 1'b1;
          end
        end
        RX_IDLE: begin
          rx_type_r   <= com_rx_btype;
          fd_com_read <= 1'b1;
          state_r     <= RX_WORK;
        end
        RX_WORK: begin
          if (!fs_com_read) begin
            if (rx_type_r == BTYPE_DATA) begin
              com_tx_btype <= BTYPE_ACK;
              fs_com_send  <= 1'b1;
              state_r      <= RX_ACK;
            end else begin
              drop_cnt <= (drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1;
              state_r  <= MAIN_WAIT;
            end
          end else begin
            fd_com_read <= 1'b1;
          end
        end
        RX_ACK: begin
          // ACK leaves before the upper-layer handoff to meet the node's reply window.
          if (fd_com_send) begin
            fs_data <= 1'b1;
            state_r <= RX_FWD;
          end else begin
            fs_com_send <= 1'b1;
          end
        end
        RX_FWD: begin
          if (fd_data) begin
            data_cnt <= data_cnt + 16'd1;
            state_r  <= MAIN_WAIT;
          end else begin
            fs_data <= 1'b1;
          end
        end
        default: begin
          state_r <= MAIN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/com_ms.md
Name: com_ms

Overview:
- Master-side link control sequencer: the host end of the same packet link that the collect-node controller drives.
- Issues command packets on request and waits for the node's INFO reply, with timeout and retry.
- Receives unsolicited DATA packets from the node, acknowledges each one, then hands it to the upper layer.
- Sits between the host command/data logic and the com tx/rx link engines. All handshakes are fs (start) / fd (done) level pairs.

Parameters:
- TIMEOUT, 32'd900: clk cycles in CMD_WAIT before a retry.
- NUM_RETRY, 8'h03: total command transmissions before the command is declared failed.
- BTYPE_INFO, 4'h1: btype of a valid command reply.
- BTYPE_DATA, 4'hE: btype of a node data packet.
- BTYPE_ACK, 4'h2: btype sent to acknowledge a DATA packet.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fs_cmd  in  1  upper layer requests a command send; held high until fd_cmd.
- fd_cmd  out  1  command finished; cmd_err/rsp_btype valid while high.
- cmd_btype  in  4  btype of the command to send; sampled when the command is accepted.
- fs_com_send  out  1  request to tx link engine.
- fd_com_send  in  1  tx link engine finished.
- fs_com_read  in  1  rx link engine holds a received packet.
- fd_com_read  out  1  packet consumed; rx engine drops fs_com_read after it.
- com_tx_btype  out  4  btype for tx engine; stable while fs_com_send is high.
- com_rx_btype  in  4  btype of the received packet; valid while fs_com_read is high.
- fs_data  out  1  DATA packet available to upper layer.
- fd_data  in  1  upper layer finished with the packet.
- rsp_btype  out  4  btype of the last command reply.
- cmd_err  out  1  last command failed (timeout, or reply != BTYPE_INFO).
- data_cnt  out  16  accepted DATA packets; wraps at 16'hFFFF -> 0.
- drop_cnt  out  8  unsolicited non-DATA packets dropped; saturates at 8'hFF.

Behaviour:
- One-hot FSM states: MAIN_IDLE, MAIN_WAIT, CMD_SEND, CMD_WAIT, CMD_WORK, CMD_DONE, RX_IDLE, RX_WORK, RX_ACK, RX_FWD.
- Reset: state=MAIN_IDLE. All outputs 0: time_cnt, retry_cnt, com_tx_btype, rsp_btype, cmd_err, data_cnt, drop_cnt, rx_type.
- MAIN_IDLE -> MAIN_WAIT unconditionally. MAIN_IDLE clears com_tx_btype only.
- MAIN_WAIT:
  - fs_com_read -> RX_IDLE (receive has priority over fs_cmd; fs_cmd stays pending).
  - else fs_cmd -> CMD_SEND: latch com_tx_btype<=cmd_btype, retry_cnt<=0, cmd_err<=0.
- CMD_SEND: fs_com_send=1; on fd_com_send -> CMD_WAIT.
- CMD_WAIT: time_cnt increments each cycle; time_cnt is 0 in every other state. Priority order:
  - fs_com_read -> CMD_WORK, latch rsp_btype<=com_rx_btype.
  - else time_cnt>=TIMEOUT-1 and retry_cnt>=NUM_RETRY-1 -> CMD_DONE, cmd_err<=1.
  - else time_cnt>=TIMEOUT-1 -> CMD_SEND, retry_cnt+1.
- CMD_WORK: fd_com_read=1; on ~fs_com_read -> CMD_DONE. On entry to CMD_DONE, cmd_err<=(rsp_btype!=BTYPE_INFO). Any btype ends the wait, including DATA from a collision.
- CMD_DONE: fd_cmd=1; on ~fs_cmd -> MAIN_WAIT.
- RX_IDLE: latch rx_type<=com_rx_btype -> RX_WORK.
- RX_WORK: fd_com_read=1; on ~fs_com_read:
  - rx_type==BTYPE_DATA -> RX_ACK, com_tx_btype<=BTYPE_ACK.
  - else -> MAIN_WAIT, drop_cnt+1 (saturating).
- RX_ACK: fs_com_send=1; on fd_com_send -> RX_FWD. The ACK goes out before the upper-layer handoff so the node's reply window is met.
- RX_FWD: fs_data=1; on fd_data -> MAIN_WAIT, data_cnt+1.
- Latency: fs_com_read sampled in MAIN_WAIT -> fd_com_read high 2 cycles later (RX_IDLE, then RX_WORK).
- Invalid/non-one-hot state -> MAIN_IDLE.
- Reset mid-operation: immediate return to MAIN_IDLE with reset values; no partial handshake is completed.

Test Plan:
- fs_cmd with cmd_btype=4'h5; tx fd after 3 cycles; reply com_rx_btype=4'h1 at 100 cycles -> com_tx_btype=5, one fs_com_send burst, fd_cmd=1, cmd_err=0, rsp_btype=1.
- fs_cmd, never reply -> exactly 3 fs_com_send bursts spaced by TIMEOUT=900 cycles in CMD_WAIT, then fd_cmd=1, cmd_err=1.
- Incoming btype 4'hE with upper layer fd_data after 5 cycles -> fd_com_read, then fs_com_send with com_tx_btype=2, then fs_data; data_cnt=1.
- Incoming btype 4'h7 -> consumed, no fs_com_send, no fs_data, drop_cnt=1. Repeat 300 times -> drop_cnt=8'hFF.
- fs_cmd and fs_com_read(btype E) asserted in the same cycle in MAIN_WAIT -> DATA path completes first (ACK sent), then command sent; fd_cmd with cmd_err per reply.
- Command reply arrives as btype 4'hE in CMD_WAIT -> fd_cmd=1, cmd_err=1, rsp_btype=E, no ACK sent. Assert rst during CMD_WAIT -> all outputs 0 next cycle.
